// File: rtl/ariane_pkg.sv
// Shared core types: functional-unit ids, exceptions and the scoreboard entry.
package ariane_pkg;

    localparam int unsigned NR_SB_ENTRIES = 4;
    localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
    localparam int unsigned NR_WB_PORTS   = 4;

    // Exception cause codes used by the front end and the functional units
    localparam logic [63:0] INSTR_ADDR_MISALIGNED = 64'd0;
    localparam logic [63:0] INSTR_ACCESS_FAULT    = 64'd1;
    localparam logic [63:0] ILLEGAL_INSTR         = 64'd2;
    localparam logic [63:0] BREAKPOINT            = 64'd3;
    localparam logic [63:0] LD_ADDR_MISALIGNED    = 64'd4;
    localparam logic [63:0] LD_ACCESS_FAULT       = 64'd5;

    typedef enum logic [3:0] {
        NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR
    } fu_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        logic [7:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        logic                     use_imm;
        exception_t               ex;
    } scoreboard_entry_t;

endpackage

// File: rtl/scoreboard.sv
// In-order issue / out-of-order writeback / in-order commit circular buffer.
module scoreboard
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES  = NR_SB_ENTRIES,
    parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    output logic                     full_o,
    input  scoreboard_entry_t        decoded_instr_i,
    input  logic                     decoded_instr_valid_i,
    output logic                     issue_ack_o,
    output logic [TRANS_ID_BITS-1:0] issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]   wb_valid_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i [NR_WB_PORTS],
    input  logic [63:0]              wdata_i    [NR_WB_PORTS],
    input  exception_t               ex_i       [NR_WB_PORTS],
    output scoreboard_entry_t        commit_instr_o,
    output logic                     commit_valid_o,
    input  logic                     commit_ack_i
);

    localparam int unsigned IDW = TRANS_ID_BITS;
    localparam int unsigned CW  = IDW + 1;
    localparam int unsigned PSW = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;

    scoreboard_entry_t     mem_q [NR_ENTRIES];
    scoreboard_entry_t     mem_d [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] occ_q, occ_d;
    logic [IDW-1:0]        head_q, head_d;
    logic [IDW-1:0]        tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  commit_fire;
    logic                  wb_hit;
    logic [PSW-1:0]        wb_sel;

    // Status and handshake outputs, all derived from registered state except the issue ack
    assign full_o           = (count_q == CW'(NR_ENTRIES));
    assign issue_ack_o      = decoded_instr_valid_i & ~full_o & ~flush_i;
    assign issue_trans_id_o = tail_q;
    assign commit_instr_o   = mem_q[head_q];
    assign commit_valid_o   = (count_q != '0) & occ_q[head_q] & mem_q[head_q].valid;
    assign commit_fire      = commit_ack_i & commit_valid_o & ~flush_i;

    // Next-state: writeback, then commit retire, then issue, with flush overriding all
    always_comb begin
        mem_d   = mem_q;
        occ_d   = occ_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wb_hit  = 1'b0;
        wb_sel  = '0;

        for (int unsigned s = 0; s < NR_ENTRIES; s++) begin
            wb_hit = 1'b0;
            wb_sel = '0;
            // Scan from the top so the lowest matching port is the one left selected
            for (int p = int'(NR_WB_PORTS) - 1; p >= 0; p--) begin
                if (wb_valid_i[p] && (trans_id_i[p] == IDW'(s))) begin
                    wb_hit = 1'b1;
                    wb_sel = PSW'(p);
                end
            end
            if (wb_hit && occ_q[s]) begin
                mem_d[s].result = wdata_i[wb_sel];
                mem_d[s].valid  = 1'b1;
                // First exception reported for an instruction is the one kept
                if (ex_i[wb_sel].valid && !mem_q[s].ex.valid) begin
                    mem_d[s].ex = ex_i[wb_sel];
                end
            end
        end

        if (commit_fire) begin
            occ_d[head_q]       = 1'b0;
            mem_d[head_q].valid = 1'b0;
            head_d              = head_q + IDW'(1);
        end

        if (issue_ack_o) begin
            mem_d[tail_q]          = decoded_instr_i;
            mem_d[tail_q].trans_id = tail_q;
            // Nothing will write back a faulting or FU-less instruction, so it is complete now
            mem_d[tail_q].valid    = decoded_instr_i.ex.valid | (decoded_instr_i.fu == NONE);
            occ_d[tail_q]          = 1'b1;
            tail_d                 = tail_q + IDW'(1);
        end

        case ({issue_ack_o, commit_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (flush_i) begin
            occ_d = '0;
            for (int unsigned s = 0; s < NR_ENTRIES; s++) begin
                mem_d[s].valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < NR_ENTRIES; s++) begin
                mem_q[s] <= '0;
            end
            occ_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/scoreboard.md
Name: scoreboard

Overview:
- Circular buffer of scoreboard_entry between issue (writer) and commit (reader).
- Issue writes decoded instructions in order; functional units write results and exceptions back out of order by trans_id; commit drains the head in order.
- Sits between the ID stage and the commit stage; functional-unit writeback ports attach in parallel.

Parameters:
- NR_ENTRIES, default NR_SB_ENTRIES (4): buffer depth; power of two.
- NR_WB_PORTS, default NR_WB_PORTS (4): number of writeback ports.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- flush_i  in  1  discard all entries
- full_o  out  1  buffer holds NR_ENTRIES entries
- decoded_instr_i  in  scoreboard_entry  instruction to issue
- decoded_instr_valid_i  in  1  issue request
- issue_ack_o  out  1  issue accepted this cycle
- issue_trans_id_o  out  TRANS_ID_BITS  slot assigned to the accepted instruction (current tail)
- wb_valid_i  in  NR_WB_PORTS  per-port writeback strobe
- trans_id_i  in  NR_WB_PORTS x TRANS_ID_BITS  writeback target slot
- wdata_i  in  NR_WB_PORTS x 64  result
- ex_i  in  NR_WB_PORTS x exception  exception raised by the functional unit
- commit_instr_o  out  scoreboard_entry  head entry
- commit_valid_o  out  1  head entry is complete
- commit_ack_i  in  1  commit consumed the head entry

Interface (already decided):
- One clock; reset is synchronous and active-low. clk_i is the clock and rst_ni the reset.

Behaviour:
- State:
  - NR_ENTRIES entries, each with an occupied bit.
  - head and tail pointers, TRANS_ID_BITS wide, wrapping modulo NR_ENTRIES.
  - count, TRANS_ID_BITS+1 wide.
- Reset (rst_ni=0 at a clock edge): all occupied and entry.valid bits cleared, head=tail=count=0.
  - Resulting outputs: full_o=0, commit_valid_o=0, issue_ack_o=0, issue_trans_id_o=0, commit_instr_o='0.
- full_o = (count==NR_ENTRIES). Taken from the registered count; no bypass from a same-cycle commit.
- Issue:
  - issue_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i (combinational).
  - On ack: slot[tail] <= decoded_instr_i, with the trans_id field overwritten by tail; occupied<=1; tail++.
  - The entry's valid is set to 1 if decoded_instr_i.ex.valid or fu==NONE, otherwise 0.
- Writeback, per port p with wb_valid_i[p]=1:
  - slot[trans_id_i[p]].result <= wdata_i[p] and .valid <= 1.
  - If ex_i[p].valid, .ex <= ex_i[p], unless the entry already holds a valid exception (earlier exception kept).
  - Writeback to an unoccupied slot is ignored.
  - Two ports targeting one slot in the same cycle: the lowest port index wins.
- Commit:
  - commit_instr_o = slot[head]; commit_valid_o = (count!=0) & slot[head].occupied & slot[head].valid.
  - Both outputs are purely from registers.
  - On commit_ack_i & commit_valid_o: slot[head] occupied<=0 and valid<=0; head++.
  - commit_ack_i without commit_valid_o is ignored.
- count: +1 on issue, -1 on commit, unchanged when both happen in the same cycle.
- Latency:
  - Writeback in cycle N makes commit_valid_o=1 in cycle N+1 if that slot is at the head.
  - An instruction issued with an exception in cycle N can commit in N+1.
- flush_i:
  - In the next cycle all occupied/valid bits are cleared, head=tail=count=0.
  - Dominates issue, writeback and commit in the same cycle (issue_ack_o=0; writes and ack have no state effect).
- Reset mid-operation: identical to flush, plus outputs forced to their reset values.
- Wrap-around: pointers roll from NR_ENTRIES-1 to 0. A full buffer (head==tail) is distinguished from an empty one only by count.

Decomposition:
- scoreboard_entry, exception, fu_t, NR_SB_ENTRIES, TRANS_ID_BITS and NR_WB_PORTS stay in ariane_pkg; no new typedefs are needed.
- No sub-module: the writeback priority loop and pointer logic live inline in one always_ff/always_comb pair.

Test Plan:
- Reset then idle: rst_ni=0 for 2 cycles -> full_o=0, commit_valid_o=0, count 0. Issue one ALU instruction -> issue_ack_o=1, issue_trans_id_o=0.
- Fill: issue 4 instructions with no writeback -> trans_ids 0,1,2,3; full_o=1 after the 4th. A 5th request -> issue_ack_o=0.
- Out-of-order writeback: slots 0..2 occupied; write slot 2 (0xCAFE), then slot 0 (0x1) -> commit_valid_o rises the cycle after the slot-0 write only. Commit slot 0, then commit_valid_o=0 until slot 1 is written back.
- Exception precedence:
  - Issue with ex.valid=1, cause=ILLEGAL_INSTR -> commit_valid_o next cycle with no writeback.
  - A later ex_i to that slot with cause LD_ACCESS_FAULT -> ex.cause stays 0x2.
- Full with simultaneous issue and commit: full buffer, head valid, commit_ack_i=1 and decoded_instr_valid_i=1 -> issue_ack_o=0, count becomes 3. Next cycle the issue is accepted with trans_id equal to the old head, covering pointer wrap.
- Flush and port conflict:
  - flush_i with 3 entries, a writeback and an issue pending -> next cycle count=0, commit_valid_o=0, issue_trans_id_o=0.
  - Ports 0 and 2 write slot 1 in the same cycle with 0xAA and 0xBB -> result=0xAA.
